// File: rtl/std_ram_reader_pkg.sv
// Shared types and buffer sizing for the streaming RAM reader.
package std_ram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BUF_DEPTH = 4;
    localparam int BUF_PTR_W = $clog2(BUF_DEPTH);
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/std_ram_reader_if.sv
// RAM read port plus valid/ready output stream of the reader.
interface std_ram_reader_if #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
);
    logic                     o_meb;
    logic [ADDRESS_WIDTH-1:0] o_adrb;
    logic [DATA_WIDTH-1:0]    i_qb;
    logic                     o_valid;
    logic                     i_ready;
    logic [DATA_WIDTH-1:0]    o_data;
    logic                     o_last;

    modport master (
        output o_meb, o_adrb, o_valid, o_data, o_last,
        input  i_qb, i_ready
    );

    modport slave (
        input  o_meb, o_adrb, o_valid, o_data, o_last,
        output i_qb, i_ready
    );
endinterface

// File: rtl/std_ram_reader_buf.sv
// Small FIFO that absorbs RAM read latency and stream back-pressure.
module std_ram_reader_buf
    import std_ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [BUF_CNT_W-1:0]  o_count
);
    logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] entries;
    logic [BUF_PTR_W-1:0]                 wr_ptr_reg;
    logic [BUF_PTR_W-1:0]                 rd_ptr_reg;
    logic [BUF_CNT_W-1:0]                 count_reg;
    logic                                 do_pop;

    assign do_pop = i_pop && (count_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] data_reg;

            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    data_reg <= '0;
                end else if (i_clr) begin
                    data_reg <= '0;
                end else if (i_push && (wr_ptr_reg == BUF_PTR_W'(gi))) begin
                    data_reg <= i_data;
                end
            end

            assign entries[gi] = data_reg;
        end
    endgenerate

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (i_clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr_reg <= wr_ptr_reg + BUF_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + BUF_PTR_W'(1);
            end
            case ({i_push, do_pop})
                2'b10:   count_reg <= count_reg + BUF_CNT_W'(1);
                2'b01:   count_reg <= count_reg - BUF_CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign o_data  = entries[rd_ptr_reg];
    assign o_count = count_reg;

endmodule

// File: rtl/std_ram_reader.sv
// Reads a run of consecutive RAM words (wrapping) and streams them out
// on a valid/ready interface, tagging the final beat with o_last.
module std_ram_reader
    import std_ram_reader_pkg::*;
#(
    parameter int WORD_SIZE     = 16,
    parameter int ADDRESS_WIDTH = (WORD_SIZE >= 2) ? $clog2(WORD_SIZE) : 1,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH-1:0] i_base,
    input  logic [ADDRESS_WIDTH:0]   i_length,
    output logic                     o_busy,
    output logic                     o_done,
    std_ram_reader_if.master         bus
);
    localparam logic [ADDRESS_WIDTH:0]   LEN_ONE  = (ADDRESS_WIDTH + 1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_TOP = ADDRESS_WIDTH'(WORD_SIZE - 1);

    state_t                   state_reg;
    logic                     inflight_reg;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic [ADDRESS_WIDTH:0]   issue_rem_reg;
    logic [ADDRESS_WIDTH:0]   beat_rem_reg;
    logic                     busy_reg;
    logic                     done_reg;

    logic [BUF_CNT_W-1:0]     buf_count;
    logic                     issue;
    logic                     valid;
    logic                     pop;
    logic                     last_beat;

    // Credit check counts the word still in the RAM pipeline; a same-cycle
    // pop deliberately does not free a slot.
    assign issue = (state_reg == ST_READ)
                && ((buf_count + BUF_CNT_W'(inflight_reg)) < BUF_CNT_W'(BUF_DEPTH))
                && (issue_rem_reg != '0);

    assign valid     = (buf_count != '0);
    assign pop       = valid && bus.i_ready;
    assign last_beat = pop && (beat_rem_reg == LEN_ONE);
    assign addr_next = (addr_reg == ADDR_TOP) ? '0 : addr_reg + ADDRESS_WIDTH'(1);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg     <= ST_IDLE;
            inflight_reg  <= 1'b0;
            addr_reg      <= '0;
            issue_rem_reg <= '0;
            beat_rem_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else if (i_clr) begin
            state_reg     <= ST_IDLE;
            inflight_reg  <= 1'b0;
            addr_reg      <= '0;
            issue_rem_reg <= '0;
            beat_rem_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                addr_reg      <= addr_next;
                issue_rem_reg <= issue_rem_reg - LEN_ONE;
            end
            if (pop) begin
                beat_rem_reg <= beat_rem_reg - LEN_ONE;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_reg      <= i_base;
                        issue_rem_reg <= i_length;
                        beat_rem_reg  <= i_length;
                        busy_reg      <= 1'b1;
                        if (i_length == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue && (issue_rem_reg == LEN_ONE)) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_beat) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Clearing the in-flight flag on abort also drops the word still in the RAM pipe.
    std_ram_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_clr),
        .i_push  (inflight_reg),
        .i_data  (bus.i_qb),
        .i_pop   (pop),
        .o_data  (bus.o_data),
        .o_count (buf_count)
    );

    assign bus.o_meb   = issue;
    assign bus.o_adrb  = addr_reg;
    assign bus.o_valid = valid;
    assign bus.o_last  = valid && (beat_rem_reg == LEN_ONE);
    assign o_busy      = busy_reg;
    assign o_done      = done_reg;

endmodule

// File: tb/tb_std_ram_reader.sv
// Directed bench for std_ram_reader: a 16-word and a 12-word instance, each with a RAM model.
`timescale 1ns/1ps
module tb_std_ram_reader;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          i_clk;
    logic          i_rst;
    logic          i_clr;
    logic          i_start;
    logic          i_start12;
    logic [AW-1:0] i_base;
    logic [AW:0]   i_length;
    logic          busy16, done16, busy12, done12;

    logic [DW-1:0] mem16 [16];
    logic [DW-1:0] mem12 [12];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int exp_adr12 [4] = '{10, 11, 0, 1};
    int exp_dat12 [4] = '{32'h1A, 32'h1B, 32'h10, 32'h11};

    int            exp_idx;
    bit            done_seen;
    bit            stall;
    logic [DW-1:0] held_data;
    logic          held_last;

    std_ram_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus16 ();
    std_ram_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus12 ();

    std_ram_reader #(.WORD_SIZE(16), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (i_clr),
        .i_start  (i_start),
        .i_base   (i_base),
        .i_length (i_length),
        .o_busy   (busy16),
        .o_done   (done16),
        .bus      (bus16)
    );

    std_ram_reader #(.WORD_SIZE(12), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut12 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (i_clr),
        .i_start  (i_start12),
        .i_base   (i_base),
        .i_length (i_length),
        .o_busy   (busy12),
        .o_done   (done12),
        .bus      (bus12)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Registered-read RAM models, one cycle of latency.
    always @(posedge i_clk) if (bus16.o_meb) bus16.i_qb <= mem16[bus16.o_adrb];
    always @(posedge i_clk) if (bus12.o_meb) bus12.i_qb <= mem12[bus12.o_adrb];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    always @(negedge i_clk) if (i_rst) check("buf_count_le4", 32'(dut.buf_count <= 3'd4), 1);

    initial begin
        i_rst = 1'b0; i_clr = 1'b0; i_start = 1'b0; i_start12 = 1'b0;
        i_base = '0; i_length = '0;
        bus16.i_ready = 1'b0; bus12.i_ready = 1'b1;
        for (int k = 0; k < 16; k++) mem16[k] = 8'h10 + 8'(k);
        for (int k = 0; k < 12; k++) mem12[k] = 8'h10 + 8'(k);
        tick(); tick();

        // Reset state
        check("rst_busy",  32'(busy16), 0);
        check("rst_done",  32'(done16), 0);
        check("rst_meb",   32'(bus16.o_meb), 0);
        check("rst_adrb",  32'(bus16.o_adrb), 0);
        check("rst_valid", 32'(bus16.o_valid), 0);
        check("rst_last",  32'(bus16.o_last), 0);
        check("rst_data",  32'(bus16.o_data), 0);
        check("rst_busy12", 32'(busy12), 0);
        i_rst = 1'b1;
        tick();
        check("idle_valid", 32'(bus16.o_valid), 0);

        // Basic transfer: base 2, length 5, ready held high
        bus16.i_ready = 1'b1; i_base = 4'd2; i_length = 5'd5; i_start = 1'b1;
        tick(); i_start = 1'b0;
        check("t1_meb_c1",  32'(bus16.o_meb), 1);
        check("t1_adrb_c1", 32'(bus16.o_adrb), 2);
        check("t1_busy_c1", 32'(busy16), 1);
        tick();
        check("t1_valid_c2", 32'(bus16.o_valid), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_valid", 32'(bus16.o_valid), 1);
            check("t1_data",  32'(bus16.o_data), 32'h12 + i);
            check("t1_last",  32'(bus16.o_last), (i == 4) ? 1 : 0);
        end
        tick();
        check("t1_done",      32'(done16), 1);
        check("t1_busy_done", 32'(busy16), 1);
        check("t1_valid_end", 32'(bus16.o_valid), 0);
        tick();
        check("t1_done_pulse", 32'(done16), 0);
        check("t1_busy_fall",  32'(busy16), 0);

        // Non-power-of-two wrap: WORD_SIZE 12, base 10, length 4
        i_base = 4'd10; i_length = 5'd4; i_start12 = 1'b1;
        tick(); i_start12 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                check("t2_meb",  32'(bus12.o_meb), 1);
                check("t2_adrb", 32'(bus12.o_adrb), exp_adr12[c-1]);
            end
            if (c >= 3) begin
                check("t2_valid", 32'(bus12.o_valid), 1);
                check("t2_data",  32'(bus12.o_data), exp_dat12[c-3]);
                check("t2_last",  32'(bus12.o_last), (c == 6) ? 1 : 0);
            end
            if (c < 6) tick();
        end
        tick();
        check("t2_done", 32'(done12), 1);
        tick();
        check("t2_busy_fall", 32'(busy12), 0);

        // Back-pressure: base 0, length 8, ready pattern 1,0,0,1
        i_base = 4'd0; i_length = 5'd8; i_start = 1'b1;
        tick(); i_start = 1'b0;
        exp_idx = 0; done_seen = 1'b0; stall = 1'b0; held_data = '0; held_last = 1'b0;
        for (int c = 0; c < 80 && !done_seen; c++) begin
            bus16.i_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (stall) begin
                check("t3_hold_valid", 32'(bus16.o_valid), 1);
                check("t3_hold_data",  32'(bus16.o_data), 32'(held_data));
                check("t3_hold_last",  32'(bus16.o_last), 32'(held_last));
            end
            if (bus16.o_valid && bus16.i_ready) begin
                check("t3_data", 32'(bus16.o_data), 32'h10 + exp_idx);
                check("t3_last", 32'(bus16.o_last), (exp_idx == 7) ? 1 : 0);
                exp_idx++;
            end
            stall     = bus16.o_valid && !bus16.i_ready;
            held_data = bus16.o_data;
            held_last = bus16.o_last;
            if (done16) done_seen = 1'b1;
            else tick();
        end
        check("t3_beats",     exp_idx, 8);
        check("t3_done_seen", 32'(done_seen), 1);
        check("t3_valid_in_done", 32'(bus16.o_valid), 0);
        tick();
        check("t3_busy_fall", 32'(busy16), 0);

        // Zero length
        bus16.i_ready = 1'b1; i_base = 4'd3; i_length = 5'd0; i_start = 1'b1;
        tick(); i_start = 1'b0;
        check("t4_done_c1",  32'(done16), 1);
        check("t4_meb_c1",   32'(bus16.o_meb), 0);
        check("t4_valid_c1", 32'(bus16.o_valid), 0);
        tick();
        check("t4_done_c2",  32'(done16), 0);
        check("t4_busy_c2",  32'(busy16), 0);
        check("t4_meb_c2",   32'(bus16.o_meb), 0);
        check("t4_valid_c2", 32'(bus16.o_valid), 0);

        // Abort after three beats, then a fresh short transfer
        i_base = 4'd0; i_length = 5'd16; i_start = 1'b1;
        tick(); i_start = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_data", 32'(bus16.o_data), 32'h10 + i);
        end
        tick();
        i_clr = 1'b1; bus16.i_ready = 1'b0;
        tick(); i_clr = 1'b0;
        check("t5_busy_clr",  32'(busy16), 0);
        check("t5_valid_clr", 32'(bus16.o_valid), 0);
        check("t5_done_clr",  32'(done16), 0);
        check("t5_meb_clr",   32'(bus16.o_meb), 0);
        tick();
        check("t5_valid_after", 32'(bus16.o_valid), 0);
        check("t5_done_after",  32'(done16), 0);
        bus16.i_ready = 1'b1; i_length = 5'd2; i_start = 1'b1;
        tick(); i_start = 1'b0;
        tick(); tick();
        check("t5_new_data0", 32'(bus16.o_data), 32'h10);
        check("t5_new_last0", 32'(bus16.o_last), 0);
        tick();
        check("t5_new_data1", 32'(bus16.o_data), 32'h11);
        check("t5_new_last1", 32'(bus16.o_last), 1);
        tick();
        check("t5_new_done",  32'(done16), 1);
        check("t5_new_valid", 32'(bus16.o_valid), 0);
        tick();

        // Asynchronous reset in DRAIN with two buffered beats
        bus16.i_ready = 1'b0; i_base = 4'd4; i_length = 5'd2; i_start = 1'b1;
        tick(); i_start = 1'b0;
        tick(); tick(); tick();
        check("t6_pre_valid", 32'(bus16.o_valid), 1);
        check("t6_pre_data",  32'(bus16.o_data), 32'h14);
        check("t6_pre_adrb",  32'(bus16.o_adrb), 6);
        i_rst = 1'b0;
        #1;
        check("t6_busy",  32'(busy16), 0);
        check("t6_done",  32'(done16), 0);
        check("t6_meb",   32'(bus16.o_meb), 0);
        check("t6_adrb",  32'(bus16.o_adrb), 0);
        check("t6_valid", 32'(bus16.o_valid), 0);
        check("t6_last",  32'(bus16.o_last), 0);
        check("t6_data",  32'(bus16.o_data), 0);
        tick();
        i_rst = 1'b1; bus16.i_ready = 1'b1;
        tick();
        check("t6_post_valid", 32'(bus16.o_valid), 0);
        check("t6_post_busy",  32'(busy16), 0);
        i_base = 4'd0; i_length = 5'd3; i_start = 1'b1;
        tick();
        i_base = 4'd9; i_length = 5'd1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_beat_valid", 32'(bus16.o_valid), 1);
            check("t6_beat_data",  32'(bus16.o_data), 32'h10 + i);
            check("t6_beat_last",  32'(bus16.o_last), (i == 2) ? 1 : 0);
        end
        tick();
        check("t6_done", 32'(done16), 1);
        tick();
        check("t6_busy_fall", 32'(busy16), 0);
        tick();
        check("t6_no_spurious_valid", 32'(bus16.o_valid), 0);
        check("t6_no_spurious_meb",   32'(bus16.o_meb), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/std_ram_reader.md
# std_ram_reader

Streaming read-side controller for a synchronous dual-port RAM with a registered read port, one cycle of read latency. On a start command it reads `i_length` consecutive words from `i_base`, wrapping modulo WORD_SIZE. It emits them on a valid/ready stream with `o_last` on the final beat. It absorbs read latency and downstream back-pressure with an internal 4-entry buffer, so it sustains 1 beat/cycle when `i_ready` is held high.

## Interface
- WORD_SIZE, 16, RAM depth in words
- ADDRESS_WIDTH, (WORD_SIZE>=2 ? $clog2(WORD_SIZE) : 1), RAM address width
- DATA_WIDTH, 8, word width
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_clr  in  1  synchronous abort/clear
- i_start  in  1  start pulse; sampled only in IDLE
- i_base  in  ADDRESS_WIDTH  first address
- i_length  in  ADDRESS_WIDTH+1  word count, 0..WORD_SIZE
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle pulse at transfer completion
- o_meb  out  1  RAM read enable
- o_adrb  out  ADDRESS_WIDTH  RAM read address
- i_qb  in  DATA_WIDTH  RAM read data, valid the cycle after `o_meb`
- o_valid  out  1  stream beat valid
- i_ready  in  1  stream beat accepted when `o_valid && i_ready`
- o_data  out  DATA_WIDTH  beat data, from the buffer head
- o_last  out  1  final beat of the transfer

## Operation
- States:
  - IDLE -> READ on `i_start` with `i_length != 0`.
  - IDLE -> DONE on `i_start` with `i_length == 0`.
  - READ -> DRAIN when the last read has issued.
  - DRAIN -> DONE on the handshake of the `o_last` beat.
  - DONE -> IDLE unconditionally.
- On start, latch `i_base` into the address counter and `i_length` into the remaining-issue and remaining-beat counters.
- Issue rule in READ: `o_meb = (buf_count + inflight) < 4 && issue_remaining != 0`.
  - `inflight` is a 1-bit flag: a read issued last cycle.
  - No same-cycle pop bypass in the credit check.
- `o_adrb` is the address counter. After each issue it increments; WORD_SIZE-1 wraps to 0, so non-power-of-2 sizes wrap explicitly.
- When `inflight` is 1, `i_qb` is written into the buffer tail that cycle.
- `o_valid = buf_count != 0`.
- `o_last` is 1 iff `o_valid` and beat_remaining == 1.
- Each handshake pops the head and decrements beat_remaining.
- Simultaneous push and pop: `buf_count` is unchanged, and pointers advance independently.
- `i_start` outside IDLE is ignored.
- `i_clr`:
  - Highest priority after reset.
  - Next state IDLE; buffer, counters and `inflight` cleared.
  - `o_done` is not pulsed, and any in-flight RAM data is discarded.
- `o_busy` is 1 in READ, DRAIN and DONE.
- `o_done` is 1 only in DONE.
- Buffer overflow is impossible by the credit rule. The bench asserts `buf_count <= 4` always.

## Timing
- Reset values: state IDLE; `o_busy` 0, `o_done` 0, `o_meb` 0, `o_adrb` 0, `o_valid` 0, `o_last` 0, `o_data` 0; buffer contents 0.
- Start accepted at edge E0. First `o_meb` in cycle 1 (after E0) with `o_adrb = i_base`. Data is pushed in cycle 2, and first `o_valid` appears in cycle 3.
- With `i_ready` held 1, beats are contiguous: N words take N beats in cycles 3..N+2. `o_done` is in cycle N+3, and `o_busy` falls in cycle N+4.
- Zero length: DONE in cycle 1 (`o_done` = 1), IDLE in cycle 2; no `o_meb`, no beats.
- Stream rule: once `o_valid` is 1, `o_data` and `o_last` hold stable until the handshake.
- Reset mid-transfer returns all outputs to reset values immediately (asynchronous).

## Structure
- Package `std_ram_reader_pkg`:
  - state enum (IDLE, READ, DRAIN, DONE)
  - localparam BUF_DEPTH = 4 and its pointer/count widths
- One natural sub-module: `std_ram_reader_buf`, a 4-entry FIFO with push/pop/count and `i_clr`, instantiated once.
- The RAM itself is external, connected at the top level. Its write port is owned by the producer.

## Test plan
- RAM preloaded with mem[k] = k+8'h10; base=2, length=5, `i_ready`=1 -> beats 8'h12..8'h16 in cycles 3..7, `o_last` on 8'h16, `o_done` in cycle 8.
- WORD_SIZE=12, base=10, length=4 -> `o_adrb` sequence 10, 11, 0, 1; data mem[10], mem[11], mem[0], mem[1].
- base=0, length=8, `i_ready` toggling 1,0,0,1,... -> all 8 words in order, no drop or duplicate, `o_data` stable while stalled, `buf_count` <= 4.
- length=0 -> `o_done` pulse 1 cycle after start, `o_valid` never 1, `o_meb` never 1.
- length=16, `i_clr` asserted after 3 beats -> next cycle IDLE, `o_valid` 0, no `o_done`. A new start (base=0, length=2) then yields mem[0], mem[1] only.
- `i_rst` low in DRAIN with 2 buffered beats -> all outputs 0 asynchronously. After release, `i_start` while busy is ignored and no spurious beats appear.
